// File: rtl/adc_uart_reporter.sv
// adc_uart_reporter
//   Periodically snapshots NCH signed BCD voltage readings and streams them as
//   one ASCII text frame over a valid/ready character interface, e.g.
//   "AD1:+1.234V  AD2:-0.567V" LF CR.
//
//   Optional feature: define ADC_REPORT_CHECKSUM_EN to insert '*' and two
//   uppercase hex characters (XOR of every byte from the first 'A' through the
//   final 'V') ahead of LF. Undefined by default: no checksum logic is built.
//
// Ports
//   clk        : clock for all logic
//   reset_n    : synchronous active-low reset
//   en         : allows new frames to start (a running frame always completes)
//   ch_bcd     : per channel c, bits [16c+15:16c] = int, tenths, hundredths, thousandths
//   ch_neg     : bit c high marks channel c negative
//   tx_data    : ASCII character offered to the transmitter
//   tx_valid   : tx_data is valid
//   tx_ready   : transmitter accepts the character this cycle
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse after the last character is accepted
//
// state | meaning
// IDLE  | counting en-qualified cycles until the next frame
// LATCH | snapshot ch_bcd / ch_neg
// SEND  | present characters, one per accepted handshake
// DONE  | pulse frame_done, return to IDLE
module adc_uart_reporter #(
  parameter int NCH         = 2,
  parameter int FRAC_DIGITS = 3,
  parameter int PERIOD      = 65536
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NCH*16-1:0] ch_bcd,
  input  logic [NCH-1:0]    ch_neg,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
);
  localparam int FIELD_LEN = 8 + FRAC_DIGITS;
  localparam int STRIDE    = FIELD_LEN + 2;      // field plus two separating spaces
  localparam int BODY_LEN  = NCH * STRIDE - 2;   // last channel has no trailing spaces
`ifdef ADC_REPORT_CHECKSUM_EN
  localparam int TAIL_LEN  = 5;
`else
  localparam int TAIL_LEN  = 2;
`endif
  localparam int FRAME_LEN = BODY_LEN + TAIL_LEN;
  localparam int CW        = $clog2(PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SEND, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [6:0]          idx_q, idx_d;
  logic [NCH*16-1:0]   snap_bcd_q, snap_bcd_d;
  logic [NCH-1:0]      snap_neg_q, snap_neg_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
`ifdef ADC_REPORT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  function automatic logic [7:0] bcd_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  // Character at the current index, derived from the snapshot.
  logic [6:0]  ch_idx, pos, rel;
  logic [15:0] cur_bcd;
  logic        cur_neg;
  logic [7:0]  ch_char;

  always_comb begin
    ch_idx  = idx_q / 7'(STRIDE);
    pos     = idx_q % 7'(STRIDE);
    rel     = idx_q - 7'(BODY_LEN);
    cur_bcd = '0;
    cur_neg = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_idx == 7'(c)) begin
        cur_bcd = snap_bcd_q[16*c +: 16];
        cur_neg = snap_neg_q[c];
      end
    end
    ch_char = 8'h20;
    if (idx_q < 7'(BODY_LEN)) begin
      if (pos == 7'd0)      ch_char = 8'h41;
      else if (pos == 7'd1) ch_char = 8'h44;
      else if (pos == 7'd2) ch_char = 8'h31 + {5'd0, ch_idx[2:0]};
      else if (pos == 7'd3) ch_char = 8'h3A;
      else if (pos == 7'd4) ch_char = cur_neg ? 8'h2D : 8'h2B;
      else if (pos == 7'd5) ch_char = bcd_char(cur_bcd[15:12]);
      else if (pos == 7'd6) ch_char = 8'h2E;
      else if (pos < 7'(7 + FRAC_DIGITS)) begin
        case (pos - 7'd7)
          7'd0:    ch_char = bcd_char(cur_bcd[11:8]);
          7'd1:    ch_char = bcd_char(cur_bcd[7:4]);
          default: ch_char = bcd_char(cur_bcd[3:0]);
        endcase
      end
      else if (pos == 7'(7 + FRAC_DIGITS)) ch_char = 8'h56;
      // remaining positions keep the space default
    end else begin
`ifdef ADC_REPORT_CHECKSUM_EN
      case (rel)
        7'd0:    ch_char = 8'h2A;
        7'd1:    ch_char = hex_char(csum_q[7:4]);
        7'd2:    ch_char = hex_char(csum_q[3:0]);
        7'd3:    ch_char = 8'h0A;
        default: ch_char = 8'h0D;
      endcase
`else
      ch_char = (rel == 7'd0) ? 8'h0A : 8'h0D;
`endif
    end
  end

  logic load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_bcd_d   = snap_bcd_q;
    snap_neg_d   = snap_neg_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
`ifdef ADC_REPORT_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (cnt_q == CW'(PERIOD - 1)) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_LATCH: begin
        snap_bcd_d = ch_bcd;
        snap_neg_d = ch_neg;
        idx_d      = '0;
`ifdef ADC_REPORT_CHECKSUM_EN
        csum_d     = '0;
`endif
        state_d    = S_SEND;
      end
      S_SEND: begin
        // First cycle of SEND only loads; afterwards reload on each accept.
        if (!tx_valid_q) begin
          load = 1'b1;
        end else if (tx_ready) begin
          if (idx_q == 7'(FRAME_LEN)) begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      tx_data_d  = ch_char;
      tx_valid_d = 1'b1;
      idx_d      = idx_q + 7'd1;
`ifdef ADC_REPORT_CHECKSUM_EN
      if (idx_q < 7'(BODY_LEN)) csum_d = csum_q ^ ch_char;
`endif
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_bcd_q   <= '0;
      snap_neg_q   <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef ADC_REPORT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_neg_q   <= snap_neg_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef ADC_REPORT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
